// File: rtl/run_sequencer.sv
// Host-side sequencer: loads a byte image into data memory, pulses the processor
// Start, waits for Done, then streams a result window back out over valid/ready.
module run_sequencer #(
    parameter int unsigned START_CYCLES   = 2,
    parameter logic [15:0] MAX_RUN_CYCLES = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        go,
    input  logic [7:0]  load_len,
    input  logic [7:0]  out_base,
    input  logic [7:0]  out_len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdat,
    input  logic [7:0]  mem_rdat,
    output logic        cpu_start,
    input  logic        cpu_done,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] run_cycles,
    output logic        err_timeout,
    output logic        seq_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  load_len_q, load_len_d;
    logic [7:0]  out_base_q, out_base_d;
    logic [7:0]  out_len_q, out_len_d;
    logic [7:0]  load_ptr_q, load_ptr_d;
    logic [7:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]  out_cnt_q, out_cnt_d;
    logic [7:0]  start_cnt_q, start_cnt_d;
    logic [15:0] run_cycles_q, run_cycles_d;
    logic        err_timeout_q, err_timeout_d;
    logic        seq_done_q, seq_done_d;
    logic        rd_pend_q, rd_pend_d;
    logic        hold_valid_q, hold_valid_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic [15:0] run_next;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            load_len_q    <= '0;
            out_base_q    <= '0;
            out_len_q     <= '0;
            load_ptr_q    <= '0;
            rd_ptr_q      <= '0;
            out_cnt_q     <= '0;
            start_cnt_q   <= '0;
            run_cycles_q  <= '0;
            err_timeout_q <= 1'b0;
            seq_done_q    <= 1'b0;
            rd_pend_q     <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            load_len_q    <= load_len_d;
            out_base_q    <= out_base_d;
            out_len_q     <= out_len_d;
            load_ptr_q    <= load_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            out_cnt_q     <= out_cnt_d;
            start_cnt_q   <= start_cnt_d;
            run_cycles_q  <= run_cycles_d;
            err_timeout_q <= err_timeout_d;
            seq_done_q    <= seq_done_d;
            rd_pend_q     <= rd_pend_d;
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_len_d    = load_len_q;
        out_base_d    = out_base_q;
        out_len_d     = out_len_q;
        load_ptr_d    = load_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        out_cnt_d     = out_cnt_q;
        start_cnt_d   = start_cnt_q;
        run_cycles_d  = run_cycles_q;
        err_timeout_d = err_timeout_q;
        rd_pend_d     = rd_pend_q;
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        seq_done_d    = (state_q == S_FINISH);
        run_next      = (run_cycles_q == 16'hFFFF) ? 16'hFFFF : run_cycles_q + 16'd1;

        in_ready  = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        mem_wdat  = '0;
        cpu_start = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    load_len_d    = load_len;
                    out_base_d    = out_base;
                    out_len_d     = out_len;
                    load_ptr_d    = '0;
                    rd_ptr_d      = '0;
                    out_cnt_d     = '0;
                    start_cnt_d   = '0;
                    run_cycles_d  = '0;
                    err_timeout_d = 1'b0;
                    state_d       = (load_len == 8'd0) ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_wr_en  = 1'b1;
                    mem_addr   = load_ptr_q;
                    mem_wdat   = in_data;
                    load_ptr_d = load_ptr_q + 8'd1;
                    if (load_ptr_q + 8'd1 == load_len_q) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cpu_start   = 1'b1;
                start_cnt_d = start_cnt_q + 8'd1;
                if (start_cnt_q == 8'(START_CYCLES - 1)) begin
                    start_cnt_d = '0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                // Done is checked first so a coincident timeout never raises the flag.
                if (cpu_done) begin
                    state_d = (out_len_q == 8'd0) ? S_FINISH : S_DRAIN;
                end else begin
                    run_cycles_d = run_next;
                    if (run_next >= MAX_RUN_CYCLES) begin
                        err_timeout_d = 1'b1;
                        state_d       = S_FINISH;
                    end
                end
            end
            S_DRAIN: begin
                if (rd_pend_q) begin
                    hold_data_d  = mem_rdat;
                    hold_valid_d = 1'b1;
                    rd_pend_d    = 1'b0;
                end else if (!hold_valid_q && rd_ptr_q != out_len_q) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = out_base_q + rd_ptr_q;
                    rd_pend_d = 1'b1;
                    rd_ptr_d  = rd_ptr_q + 8'd1;
                end
                if (hold_valid_q && out_ready) begin
                    hold_valid_d = 1'b0;
                    out_cnt_d    = out_cnt_q + 8'd1;
                    if (out_cnt_q + 8'd1 == out_len_q) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign out_valid   = hold_valid_q;
    assign out_data    = hold_data_q;
    assign run_cycles  = run_cycles_q;
    assign err_timeout = err_timeout_q;
    assign seq_done    = seq_done_q;

endmodule
